// File: rtl/hov_bridge_pkg.sv
// Shared constants, step FSM state type and helper functions for the Hovalaag host bridge.
package hov_bridge_pkg;

  localparam logic [2:0] WR_INSTR   = 3'd0;
  localparam logic [2:0] WR_IN1     = 3'd1;
  localparam logic [2:0] WR_IN2     = 3'd2;
  localparam logic [2:0] WR_EXEC    = 3'd3;
  localparam logic [2:0] WR_OUT_POP = 3'd4;
  localparam logic [2:0] WR_CLEAR   = 3'd5;

  localparam logic [2:0] RD_STATUS = 3'd0;
  localparam logic [2:0] RD_OUT_LO = 3'd1;
  localparam logic [2:0] RD_OUT_HI = 3'd2;
  localparam logic [2:0] RD_PC     = 3'd3;
  localparam logic [2:0] RD_COUNTS = 3'd4;
  localparam logic [2:0] RD_SEG7   = 3'd5;

  localparam int ST_BUSY       = 0;
  localparam int ST_STALLED    = 1;
  localparam int ST_OUT_AVAIL  = 2;
  localparam int ST_HEAD_CH    = 3;
  localparam int ST_IN1_FULL   = 4;
  localparam int ST_IN2_FULL   = 5;
  localparam int ST_ERR        = 6;
  localparam int ST_INSTR_FULL = 7;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_STALL, S_STEP} step_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic logic [3:0] sat4(input int unsigned v);
    if (v > 32'd15) begin
      return 4'd15;
    end else begin
      return v[3:0];
    end
  endfunction

endpackage

// File: rtl/hov_sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop (both honoured even when full); head reads 0 when empty.
module hov_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_C  = (AW+1)'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == ZERO_C);
  assign full      = (count_r == DEPTH_C);
  assign count     = count_r;
  assign do_pop_s  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= ZERO_C;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hov_host_bridge.sv
// Host bridge for the Hovalaag core: chunked INSTR/IN loading, IN/OUT FIFOs and a stalling step FSM.
// Define HOV_BRIDGE_SEG7_EN to add the 7-segment view of the OUT head on rd_sel 5.
module hov_host_bridge
  import hov_bridge_pkg::*;
#(
  parameter int BUS_W     = 6,
  parameter int DATA_W    = 12,
  parameter int INSTR_W   = 32,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [2:0]         wr_sel,
  input  logic [BUS_W-1:0]   wr_data,
  input  logic [2:0]         rd_sel,
  output logic [7:0]         rd_data,
  output logic               cpu_step,
  output logic [INSTR_W-1:0] cpu_instr,
  output logic [DATA_W-1:0]  cpu_in1,
  output logic [DATA_W-1:0]  cpu_in2,
  input  logic               cpu_in1_adv,
  input  logic               cpu_in2_adv,
  input  logic               cpu_out_valid,
  input  logic               cpu_out_sel,
  input  logic [DATA_W-1:0]  cpu_out,
  input  logic [7:0]         cpu_pc
);

  localparam int NI  = ceil_div(INSTR_W, BUS_W);
  localparam int NW  = ceil_div(DATA_W, BUS_W);
  localparam int ICW = $clog2(NI + 1);
  localparam int WCW = $clog2(NW + 1);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [ICW-1:0]     NI_C       = ICW'(NI);
  localparam logic [WCW-1:0]     NW_LAST    = WCW'(NW - 1);
  localparam logic [INSTR_W-1:0] INSTR_MASK = INSTR_W'({BUS_W{1'b1}});
  localparam logic [DATA_W-1:0]  WORD_MASK  = DATA_W'({BUS_W{1'b1}});

  step_state_t             state_r;
  logic                    cpu_step_r;
  logic [INSTR_W-1:0]      instr_r;
  logic [ICW-1:0]          instr_cnt_r;
  logic                    ovf_r;
  logic                    udf_r;

  logic                    instr_full_s;
  logic                    wr_instr_s;
  logic                    wr_exec_s;
  logic                    wr_clear_s;
  logic                    out_pop_s;
  logic                    step_s;
  logic                    blocked_s;
  logic [1:0]              in_adv_s;
  logic [1:0]              in_full_s;
  logic [1:0]              in_empty_s;
  logic [1:0]              in_ovf_s;
  logic [1:0][DATA_W-1:0]  in_head_s;
  logic [1:0][IAW:0]       in_count_s;
  logic [DATA_W:0]         out_head_s;
  logic                    out_full_s;
  logic                    out_empty_s;
  logic [OAW:0]            out_count_s;
  logic [7:0]              status_s;

  assign instr_full_s = (instr_cnt_r == NI_C);
  assign step_s       = (state_r == S_STEP);
  assign wr_instr_s   = wr_en && (wr_sel == WR_INSTR) && (state_r == S_IDLE) && !instr_full_s;
  assign wr_exec_s    = wr_en && (wr_sel == WR_EXEC);
  assign wr_clear_s   = wr_en && (wr_sel == WR_CLEAR);
  assign out_pop_s    = wr_en && (wr_sel == WR_OUT_POP);
  assign in_adv_s     = {cpu_in2_adv, cpu_in1_adv};
  assign blocked_s    = (cpu_in1_adv && in_empty_s[0]) || (cpu_in2_adv && in_empty_s[1]) ||
                        (cpu_out_valid && out_full_s);

  assign cpu_step  = cpu_step_r;
  assign cpu_instr = instr_r;
  assign cpu_in1   = in_head_s[0];
  assign cpu_in2   = in_head_s[1];

  // Instruction assembly: chunk k lands at bit k*BUS_W; bits beyond INSTR_W fall off the shift
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r     <= {INSTR_W{1'b0}};
      instr_cnt_r <= ICW'(0);
    end else if (wr_clear_s || step_s) begin
      instr_cnt_r <= ICW'(0);
    end else if (wr_instr_s) begin
      instr_r     <= (instr_r & ~(INSTR_MASK << (instr_cnt_r * BUS_W))) |
                     (INSTR_W'(wr_data) << (instr_cnt_r * BUS_W));
      instr_cnt_r <= instr_cnt_r + ICW'(1);
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_in
    localparam logic [2:0] SEL_C = (c == 0) ? WR_IN1 : WR_IN2;
    logic [DATA_W-1:0] buf_r;
    logic [DATA_W-1:0] word_s;
    logic [WCW-1:0]    cnt_r;
    logic              wr_s;
    logic              push_s;
    logic              pop_s;

    assign wr_s        = wr_en && (wr_sel == SEL_C);
    assign push_s      = wr_s && (cnt_r == NW_LAST);
    assign pop_s       = step_s && in_adv_s[c];
    assign in_ovf_s[c] = push_s && in_full_s[c] && !pop_s;
    assign word_s      = (buf_r & ~(WORD_MASK << (cnt_r * BUS_W))) |
                         (DATA_W'(wr_data) << (cnt_r * BUS_W));

    // Per-channel chunk counter; the last chunk pushes the word and rewinds
    always_ff @(posedge clk) begin
      if (reset) begin
        buf_r <= {DATA_W{1'b0}};
        cnt_r <= WCW'(0);
      end else if (wr_clear_s) begin
        cnt_r <= WCW'(0);
      end else if (wr_s) begin
        buf_r <= word_s;
        cnt_r <= push_s ? WCW'(0) : cnt_r + WCW'(1);
      end
    end

    hov_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (word_s),
      .rdata (in_head_s[c]),
      .full  (in_full_s[c]),
      .empty (in_empty_s[c]),
      .count (in_count_s[c])
    );
  end

  hov_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (step_s && cpu_out_valid),
    .pop   (out_pop_s),
    .wdata ({cpu_out_sel, cpu_out}),
    .rdata (out_head_s),
    .full  (out_full_s),
    .empty (out_empty_s),
    .count (out_count_s)
  );

  // Step FSM: fire the core only once every needed queue can serve it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cpu_step_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          cpu_step_r <= 1'b0;
          if (wr_exec_s && instr_full_s) state_r <= S_CHECK;
        end
        S_CHECK, S_STALL: begin
          if (blocked_s) begin
            state_r    <= S_STALL;
            cpu_step_r <= 1'b0;
          end else begin
            state_r    <= S_STEP;
            cpu_step_r <= 1'b1;
          end
        end
        S_STEP: begin
          state_r    <= S_IDLE;
          cpu_step_r <= 1'b0;
        end
        default: begin
          state_r    <= S_IDLE;
          cpu_step_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (|in_ovf_s);
      udf_r <= udf_r | (out_pop_s && out_empty_s);
    end
  end

`ifdef HOV_BRIDGE_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction
`endif

  // Status word and host read mux
  always_comb begin
    status_s                = 8'd0;
    status_s[ST_BUSY]       = (state_r != S_IDLE);
    status_s[ST_STALLED]    = (state_r == S_STALL);
    status_s[ST_OUT_AVAIL]  = (out_count_s != (OAW+1)'(0));
    status_s[ST_HEAD_CH]    = out_head_s[DATA_W];
    status_s[ST_IN1_FULL]   = in_full_s[0];
    status_s[ST_IN2_FULL]   = in_full_s[1];
    status_s[ST_ERR]        = ovf_r | udf_r;
    status_s[ST_INSTR_FULL] = instr_full_s;
    rd_data                 = 8'd0;
    case (rd_sel)
      RD_STATUS: rd_data = status_s;
      RD_OUT_LO: rd_data = out_head_s[7:0];
      RD_OUT_HI: rd_data = 8'(out_head_s[DATA_W-1:8]);
      RD_PC:     rd_data = cpu_pc;
      RD_COUNTS: rd_data = {sat4(32'(in_count_s[1])), sat4(32'(in_count_s[0]))};
`ifdef HOV_BRIDGE_SEG7_EN
      RD_SEG7:   rd_data = {out_head_s[DATA_W], seg7(out_head_s[3:0])};
`else
      RD_SEG7:   rd_data = 8'd0;
`endif
      default:   rd_data = 8'd0;
    endcase
  end

endmodule

// File: doc/hov_host_bridge.md
Name: hov_host_bridge

Overview:
Parametrised host bridge for the Hovalaag core, replacing the fixed one-hot loader with encoded selects.
- Assembles instruction and IN words from narrow host chunks, and buffers IN1/IN2 and OUT1/OUT2 in FIFOs.
- Runs a step FSM that only fires the core when its queues can satisfy the instruction, and stalls otherwise.
- Sits between the chip I/O pins and the core; the core's clock enable is `cpu_step`.

Parameters:
- BUS_W, 6: host write chunk width.
- DATA_W, 12: IN/OUT word width (9..16).
- INSTR_W, 32: instruction width.
- IN_DEPTH, 4: entries per IN FIFO (power of 2).
- OUT_DEPTH, 4: entries in OUT FIFO (power of 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  host write strobe
- wr_sel  in  3  write target: 0 INSTR chunk, 1 IN1 chunk, 2 IN2 chunk, 3 EXEC, 4 OUT pop, 5 clear chunk counters
- wr_data  in  BUS_W  write chunk
- rd_sel  in  3  read select
- rd_data  out  8  combinational read data
- cpu_step  out  1  one-cycle core clock enable
- cpu_instr  out  INSTR_W  assembled instruction
- cpu_in1  out  DATA_W  IN1 FIFO head (0 if empty)
- cpu_in2  out  DATA_W  IN2 FIFO head (0 if empty)
- cpu_in1_adv  in  1  core consumes IN1 (decoded combinationally from cpu_instr)
- cpu_in2_adv  in  1  core consumes IN2
- cpu_out_valid  in  1  core produces OUT
- cpu_out_sel  in  1  0 = OUT1, 1 = OUT2
- cpu_out  in  DATA_W  core output word, valid in the step cycle
- cpu_pc  in  8  core PC

Behaviour:
- Reset: all FIFOs empty, chunk counters 0, instr 0, sticky flags 0, FSM IDLE, cpu_step 0.
- Reset mid-step aborts the step: no push, no pop.
- INSTR assembly:
  - NI = ceil(INSTR_W/BUS_W).
  - Write k (k = chunk counter) loads bits [k*BUS_W +: BUS_W], truncated at INSTR_W; the counter then increments.
  - After write NI, instr_full = 1. Further INSTR writes are ignored.
- IN assembly, per channel:
  - NW = ceil(DATA_W/BUS_W).
  - The NW-th chunk pushes the assembled word and resets that channel's counter.
  - If the FIFO is full, the word is dropped and the overflow sticky is set.
- Push and pop in the same cycle are both honoured, including when the FIFO is full.
- FSM states IDLE, CHECK, STALL, STEP:
  - IDLE: EXEC with instr_full -> CHECK. EXEC in any other state, or with !instr_full, is ignored.
  - CHECK: a need is blocked if (cpu_in1_adv and IN1 empty) or (cpu_in2_adv and IN2 empty) or (cpu_out_valid and OUT full). Any blocked need -> STALL, else -> STEP.
  - STALL: re-evaluate the CHECK condition every cycle; -> STEP the cycle after it clears.
  - STEP: assert cpu_step for exactly 1 cycle; pop IN1/IN2 if adv; push {cpu_out_sel, cpu_out} if cpu_out_valid. Then clear instr_full and the INSTR counter, and go to IDLE.
  - EXEC-to-cpu_step latency: 2 cycles if not stalled.
- Host writes while not IDLE:
  - INSTR writes are ignored.
  - IN writes and OUT pops proceed (this is what resolves a stall).
- OUT pop (wr_sel 4): pops the head; pop when empty is a no-op and sets the underflow sticky.
- Clear (wr_sel 5): zeroes all chunk counters and instr_full; FIFOs are untouched.
- Sticky flags clear only on reset.
- rd_data by rd_sel:
  - 0: status [0] busy, [1] stalled, [2] out_avail, [3] head channel, [4] in1_full, [5] in2_full, [6] overflow|underflow, [7] instr_full
  - 1: OUT head [7:0]
  - 2: OUT head [DATA_W-1:8], zero-extended
  - 3: cpu_pc
  - 4: {IN2 count, IN1 count}, 4 bits each, saturating at 15
  - 5: see Optional Feature
  - 6, 7: zero
  - Empty OUT FIFO reads 0.

Optional Feature:
- Macro HOV_BRIDGE_SEG7_EN.
- Defined: rd_sel 5 = {head channel, 7-segment code of OUT head [3:0]}, segments a..g on bits 0..6, active-high, hex 0-F.
- Undefined: rd_sel 5 reads 0 and no decoder is built.

Decomposition:
- Package hov_bridge_pkg:
  - wr_sel / rd_sel constants.
  - Status bit indices.
  - FSM state enum.
  - Chunk-count functions: ceil division.
- Sub-module hov_sync_fifo (WIDTH, DEPTH):
  - Simultaneous push/pop, full, empty, count.
  - Instantiated three times.

Test Plan:
- 6 INSTR writes with 0x3F each, EXEC, core adv/valid all 0 -> cpu_step high exactly on cycle 2 after EXEC; cpu_instr = 0xFFFFFFFF; instr_full then 0.
- Push IN1 chunks 0x05, 0x01 -> rd_sel 4 = 0x01; cpu_in1 = 0x045. Step with cpu_in1_adv = 1 -> count 0, cpu_in1 = 0.
- EXEC with cpu_in2_adv = 1 and IN2 empty -> status bits busy and stalled set, no cpu_step. Push IN2 word 0x7FF -> cpu_step fires; IN2 popped.
- Four steps with cpu_out_valid = 1 and cpu_out = 0xA5C, sel 1 -> OUT full. Fifth step stalls until a wr_sel 4 pop. rd_sel 1 = 0x5C, rd_sel 2 = 0x0A, status bit 3 = 1.
- Fifth IN1 word into a full FIFO -> dropped, status bit 6 set. Pop on empty OUT -> bit 6 stays set; reset -> status 0x00.
- HOV_BRIDGE_SEG7_EN defined, OUT head 0x003 on OUT1 -> rd_sel 5 = 0x4F. Undefined -> rd_sel 5 = 0x00.
